// File: rtl/ppg_led_sequencer.sv
// RED/IR LED time-multiplexer for the fingerclip PPG front end: dead-time gaps, end-of-window
// sampling, and a per-channel saturating DC-compensation tracking loop with lock detection.
module ppg_led_sequencer #(
   parameter int unsigned ON_CYCLES  = 40,
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned TH_HIGH    = 200,
   parameter int unsigned TH_LOW     = 55,
   parameter int unsigned DC_INIT    = 64,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] pga_gain_cfg,
   input  logic [7:0] Vppg,
   output logic       LED_RED,
   output logic       LED_IR,
   output logic [6:0] DC_Comp,
   output logic [3:0] PGA_Gain,
   output logic [7:0] sample,
   output logic       sample_valid,
   output logic       sample_is_ir,
   output logic [1:0] dc_locked
);

   localparam int unsigned CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam int unsigned LK_W    = $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [LK_W-1:0]  LK_MAX   = LK_W'(LOCK_COUNT);
   localparam logic [7:0]       TH_HI    = 8'(TH_HIGH);
   localparam logic [7:0]       TH_LO    = 8'(TH_LOW);
   localparam logic [6:0]       DC_RST   = 7'(DC_INIT);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StRedOn = 3'd1;
   localparam logic [2:0] StGap1  = 3'd2;
   localparam logic [2:0] StIrOn  = 3'd3;
   localparam logic [2:0] StGap2  = 3'd4;

   logic [2:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [6:0]       dc_red_q, dc_ir_q;
   logic [LK_W-1:0]  lock_red_q, lock_ir_q;

   logic             cap_red, cap_ir;
   logic [6:0]       cap_dc, dc_nxt;
   logic [LK_W-1:0]  cap_lock, lock_nxt;
   logic             in_win;

   // Both channels share one update datapath; only one capture edge can occur per cycle.
   always_comb begin
      cap_red  = (state_q == StRedOn) && (cnt_q == ON_LAST);
      cap_ir   = (state_q == StIrOn) && (cnt_q == ON_LAST);
      cap_dc   = cap_ir ? dc_ir_q : dc_red_q;
      cap_lock = cap_ir ? lock_ir_q : lock_red_q;
      in_win   = (Vppg >= TH_LO) && (Vppg <= TH_HI);

      dc_nxt = cap_dc;
      if ((Vppg > TH_HI) && (cap_dc != 7'd127)) begin
         dc_nxt = cap_dc + 7'd1;
      end else if ((Vppg < TH_LO) && (cap_dc != 7'd0)) begin
         dc_nxt = cap_dc - 7'd1;
      end

      lock_nxt = '0;
      if (in_win) begin
         lock_nxt = (cap_lock == LK_MAX) ? cap_lock : cap_lock + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         dc_red_q     <= DC_RST;
         dc_ir_q      <= DC_RST;
         lock_red_q   <= '0;
         lock_ir_q    <= '0;
         LED_RED      <= 1'b0;
         LED_IR       <= 1'b0;
         DC_Comp      <= DC_RST;
         PGA_Gain     <= 4'd0;
         sample       <= 8'd0;
         sample_valid <= 1'b0;
         sample_is_ir <= 1'b0;
         dc_locked    <= 2'b00;
      end else begin
         sample_valid <= 1'b0;
         cnt_q        <= cnt_q + 1'b1;
         case (state_q)
            StIdle: begin
               LED_RED <= 1'b0;
               LED_IR  <= 1'b0;
               DC_Comp <= dc_red_q;
               cnt_q   <= '0;
               if (enable) begin
                  PGA_Gain <= pga_gain_cfg;
                  LED_RED  <= 1'b1;
                  state_q  <= StRedOn;
               end
            end
            StRedOn: begin
               if (cap_red) begin
                  LED_RED      <= 1'b0;
                  state_q      <= StGap1;
                  cnt_q        <= '0;
                  DC_Comp      <= dc_ir_q;
                  dc_red_q     <= dc_nxt;
                  lock_red_q   <= lock_nxt;
                  dc_locked[0] <= (lock_nxt == LK_MAX);
                  sample       <= Vppg;
                  sample_valid <= 1'b1;
                  sample_is_ir <= 1'b0;
               end
            end
            StGap1: begin
               if (cnt_q == GAP_LAST) begin
                  LED_IR  <= 1'b1;
                  state_q <= StIrOn;
                  cnt_q   <= '0;
               end
            end
            StIrOn: begin
               if (cap_ir) begin
                  LED_IR       <= 1'b0;
                  state_q      <= StGap2;
                  cnt_q        <= '0;
                  DC_Comp      <= dc_red_q;
                  dc_ir_q      <= dc_nxt;
                  lock_ir_q    <= lock_nxt;
                  dc_locked[1] <= (lock_nxt == LK_MAX);
                  sample       <= Vppg;
                  sample_valid <= 1'b1;
                  sample_is_ir <= 1'b1;
               end
            end
            StGap2: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (enable) begin
                     PGA_Gain <= pga_gain_cfg;
                     LED_RED  <= 1'b1;
                     state_q  <= StRedOn;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            default: begin
               LED_RED <= 1'b0;
               LED_IR  <= 1'b0;
               cnt_q   <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ppg_led_sequencer.sv
// Scoreboard bench for ppg_led_sequencer: expected strobes are queued by the stimulus and
// checked by an independent monitor; timing, reset and saturation are checked directly.
module tb_ppg_led_sequencer;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic [3:0] pga_gain_cfg;
   logic [7:0] Vppg;
   logic       LED_RED, LED_IR;
   logic [6:0] DC_Comp;
   logic [3:0] PGA_Gain;
   logic [7:0] sample;
   logic       sample_valid, sample_is_ir;
   logic [1:0] dc_locked;

   always #5 clk = ~clk;

   ppg_led_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .pga_gain_cfg (pga_gain_cfg),
      .Vppg         (Vppg),
      .LED_RED      (LED_RED),
      .LED_IR       (LED_IR),
      .DC_Comp      (DC_Comp),
      .PGA_Gain     (PGA_Gain),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sample_is_ir (sample_is_ir),
      .dc_locked    (dc_locked)
   );

   typedef struct packed {
      logic [7:0] s;
      logic       ir;
      logic [6:0] dc;
      logic [1:0] lk;
      logic [3:0] g;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   overlap = 0;

   // Reference model of the tracking loop
   int         m_dc_r, m_dc_i, m_lk_r, m_lk_i;
   logic [3:0] m_gain;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int dc_step(input int dc, input int v);
      if (v > 200 && dc < 127) return dc + 1;
      if (v < 55 && dc > 0) return dc - 1;
      return dc;
   endfunction

   function automatic int lk_step(input int lk, input int v);
      if (v < 55 || v > 200) return 0;
      return (lk < 4) ? lk + 1 : lk;
   endfunction

   task automatic model_reset();
      m_dc_r = 64; m_dc_i = 64; m_lk_r = 0; m_lk_i = 0;
   endtask

   task automatic push_half(input int v, input bit ir);
      exp_t e;
      if (!ir) begin
         m_dc_r = dc_step(m_dc_r, v);
         m_lk_r = lk_step(m_lk_r, v);
      end else begin
         m_dc_i = dc_step(m_dc_i, v);
         m_lk_i = lk_step(m_lk_i, v);
      end
      e.s  = v[7:0];
      e.ir = ir;
      e.dc = ir ? m_dc_r[6:0] : m_dc_i[6:0];
      e.lk = {(m_lk_i == 4), (m_lk_r == 4)};
      e.g  = m_gain;
      q.push_back(e);
   endtask

   task automatic push_frames(input int n, input int v);
      for (int i = 0; i < n; i++) begin
         push_half(v, 1'b0);
         push_half(v, 1'b1);
      end
   endtask

   task automatic drain();
      int cyc = 0;
      int lim = q.size() * 100 + 200;
      while (q.size() != 0 && cyc < lim) begin
         @(negedge clk);
         cyc++;
      end
      chk("drain_timeout", q.size(), 0);
   endtask

   // Monitor: LED exclusivity every cycle, and every strobe against the queue
   always @(negedge clk) begin
      if (LED_RED && LED_IR) overlap++;
      if (sample_valid) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got strobe tag=%0d sample=%0d expected none",
                     sample_is_ir, sample);
         end else begin
            mon_e = q.pop_front();
            chk("sb_sample", int'(sample), int'(mon_e.s));
            chk("sb_tag", int'(sample_is_ir), int'(mon_e.ir));
            chk("sb_dc_comp", int'(DC_Comp), int'(mon_e.dc));
            chk("sb_locked", int'(dc_locked), int'(mon_e.lk));
            chk("sb_gain", int'(PGA_Gain), int'(mon_e.g));
         end
      end
   end

   task automatic measure_frame();
      int r = 0, g1 = 0, ir = 0, g2 = 0, w = 0;
      while (!LED_RED && w < 20) begin @(negedge clk); w++; end
      while (LED_RED && r < 200) begin r++; @(negedge clk); end
      while (!LED_RED && !LED_IR && g1 < 200) begin g1++; @(negedge clk); end
      while (LED_IR && ir < 200) begin ir++; @(negedge clk); end
      while (!LED_RED && !LED_IR && g2 < 200) begin g2++; @(negedge clk); end
      chk("red_on_cycles", r, 40);
      chk("gap1_cycles", g1, 4);
      chk("ir_on_cycles", ir, 40);
      chk("gap2_cycles", g2, 4);
      chk("frame_period", r + g1 + ir + g2, 88);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int on;
      reset = 1'b1; enable = 1'b1; Vppg = 8'd128; pga_gain_cfg = 4'd5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_led_red", int'(LED_RED), 0);
      chk("rst_led_ir", int'(LED_IR), 0);
      chk("rst_dc_comp", int'(DC_Comp), 64);
      chk("rst_pga_gain", int'(PGA_Gain), 0);
      chk("rst_valid", int'(sample_valid), 0);
      chk("rst_locked", int'(dc_locked), 0);

      // Nominal frames at mid-scale: lock builds over 4 frames
      model_reset();
      m_gain = 4'd5;
      push_frames(5, 128);
      reset = 1'b0;
      measure_frame();
      drain();
      chk("nominal_locked", int'(dc_locked), 3);
      chk("nominal_dc_comp", int'(DC_Comp), 64);
      chk("nominal_gain", int'(PGA_Gain), 5);

      // Reset during IR_ON at cnt = 20
      push_half(128, 1'b0);
      w = 0;
      while (!LED_IR && w < 300) begin @(negedge clk); w++; end
      chk("ir_on_seen", int'(LED_IR), 1);
      repeat (20) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_led_ir", int'(LED_IR), 0);
      chk("midrst_led_red", int'(LED_RED), 0);
      chk("midrst_dc_comp", int'(DC_Comp), 64);
      chk("midrst_locked", int'(dc_locked), 0);
      chk("midrst_valid", int'(sample_valid), 0);
      chk("midrst_queue", q.size(), 0);

      // Restart with enable held through reset, then drop enable mid-RED_ON
      model_reset();
      m_gain = 4'd5;
      push_frames(1, 128);
      reset = 1'b0;
      @(negedge clk);
      chk("restart_led_red", int'(LED_RED), 1);
      chk("restart_led_ir", int'(LED_IR), 0);
      repeat (10) @(negedge clk);
      enable = 1'b0;
      pga_gain_cfg = 4'd9;
      drain();
      on = 0;
      repeat (40) begin
         @(negedge clk);
         if (LED_RED || LED_IR) on++;
      end
      chk("idle_leds_on", on, 0);
      chk("idle_gain_held", int'(PGA_Gain), 5);

      // Re-enable with new gain, saturate high
      m_gain = 4'd9;
      Vppg = 8'd255;
      push_frames(64, 255);
      enable = 1'b1;
      @(negedge clk);
      chk("reenable_led_red", int'(LED_RED), 1);
      chk("reenable_gain", int'(PGA_Gain), 9);
      drain();
      chk("sat_high_dc", int'(DC_Comp), 127);
      chk("sat_high_locked", int'(dc_locked), 0);

      // Saturate low from a fresh reset
      reset = 1'b1;
      Vppg = 8'd0;
      @(negedge clk);
      model_reset();
      push_frames(65, 0);
      reset = 1'b0;
      drain();
      enable = 1'b0;
      chk("sat_low_dc", int'(DC_Comp), 0);
      chk("sat_low_locked", int'(dc_locked), 0);
      repeat (100) @(negedge clk);
      chk("sat_low_idle_dc", int'(DC_Comp), 0);
      chk("led_overlap", overlap, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
